// File: rtl/psram_ctrl_if.sv
// ============================================================================
// Module      : psram_ctrl_if
// Description : Core-side word bus between the RV32 memory port and the
//               serial PSRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface psram_ctrl_if;
  logic [23:0] mem_addr;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_done;

  // Core side: issues requests, observes the busy/done handshake
  modport master (
    output mem_addr, mem_rstrb, mem_wmask, mem_wdata,
    input  mem_rdata, mem_busy, mem_done
  );

  // Controller side
  modport slave (
    input  mem_addr, mem_rstrb, mem_wmask, mem_wdata,
    output mem_rdata, mem_busy, mem_done
  );
endinterface

`default_nettype wire

// File: rtl/psram_ctrl.sv
// ============================================================================
// Module      : psram_ctrl
// Description : Word-access controller for a serial PSRAM behind a byte-wide
//               SPI engine. Runs the power-up reset sequence, then turns each
//               bus read/write into one CE_B-framed SPI transaction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psram_ctrl #(
  parameter int         INIT_CYCLES = 2400,
  parameter int         CE_GAP      = 4,
  parameter logic [7:0] CMD_READ    = 8'h03,
  parameter logic [7:0] CMD_WRITE   = 8'h02
) (
  input  logic         clk,
  input  logic         reset,
  psram_ctrl_if.slave  bus,
  output logic         ram_ce_b,
  output logic         spi_strb,
  output logic [7:0]   spi_tx,
  input  logic [7:0]   spi_rx,
  input  logic         spi_valid
);

  localparam int c_CNT_MAX = (INIT_CYCLES > CE_GAP) ? INIT_CYCLES : CE_GAP;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [3:0] c_INIT_WAIT  = 4'd0;
  localparam logic [3:0] c_INIT_RSTEN = 4'd1;
  localparam logic [3:0] c_INIT_GAP   = 4'd2;
  localparam logic [3:0] c_INIT_RST   = 4'd3;
  localparam logic [3:0] c_GAP        = 4'd4;
  localparam logic [3:0] c_IDLE       = 4'd5;
  localparam logic [3:0] c_CMD        = 4'd6;
  localparam logic [3:0] c_ADDR       = 4'd7;
  localparam logic [3:0] c_DATA       = 4'd8;
  localparam logic [3:0] c_FINISH     = 4'd9;

  logic [3:0]         r_state;
  logic [3:0]         w_state_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_issued;     // a byte is outstanding in the SPI engine
  logic [1:0]         r_idx;        // byte index within ADDR or DATA
  logic [23:0]        r_addr;       // PSRAM start address of the access
  logic [31:0]        r_wdata;
  logic               r_is_wr;
  logic [1:0]         r_first;
  logic [1:0]         r_last;
  logic [23:0]        r_rx;         // read bytes 0..2 collected before commit
  logic [31:0]        r_rdata;
  logic               r_ce_b;

  logic               w_byte_done;
  logic               w_req_wr;
  logic               w_req_rd;
  logic               w_accept;
  logic               w_init_hit;
  logic               w_gap_hit;
  logic               w_byte_state;
  logic               w_framed_next;
  logic [1:0]         w_first;
  logic [1:0]         w_last;
  logic [7:0]         w_tx;
  logic               w_unused;

  // Word alignment discards the low address bits
  assign w_unused = ^bus.mem_addr[1:0];

  assign w_byte_done = r_issued & spi_valid;
  assign w_req_wr    = (bus.mem_wmask != 4'd0);
  assign w_req_rd    = bus.mem_rstrb;
  assign w_accept    = (r_state == c_IDLE) && (w_req_wr || w_req_rd);
  assign w_init_hit  = (r_cnt == c_CNT_W'(INIT_CYCLES - 1));
  assign w_gap_hit   = (r_cnt == c_CNT_W'(CE_GAP - 1));
  assign ram_ce_b    = r_ce_b;
  assign bus.mem_rdata = r_rdata;

  // Lowest and highest enabled byte lane of the write mask
  always_comb begin
    w_first = 2'd0;
    w_last  = 2'd0;
    if (bus.mem_wmask[0])      w_first = 2'd0;
    else if (bus.mem_wmask[1]) w_first = 2'd1;
    else if (bus.mem_wmask[2]) w_first = 2'd2;
    else if (bus.mem_wmask[3]) w_first = 2'd3;
    if (bus.mem_wmask[3])      w_last = 2'd3;
    else if (bus.mem_wmask[2]) w_last = 2'd2;
    else if (bus.mem_wmask[1]) w_last = 2'd1;
    else if (bus.mem_wmask[0]) w_last = 2'd0;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_INIT_WAIT;
    else       r_state <= w_state_next;
  end

  // Next-state logic: byte states advance only on the awaited spi_valid
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_INIT_WAIT:  if (w_init_hit)  w_state_next = c_INIT_RSTEN;
      c_INIT_RSTEN: if (w_byte_done) w_state_next = c_INIT_GAP;
      c_INIT_GAP:   if (w_gap_hit)   w_state_next = c_INIT_RST;
      c_INIT_RST:   if (w_byte_done) w_state_next = c_GAP;
      c_GAP:        if (w_gap_hit)   w_state_next = c_IDLE;
      c_IDLE:       if (w_accept)    w_state_next = c_CMD;
      c_CMD:        if (w_byte_done) w_state_next = c_ADDR;
      c_ADDR:       if (w_byte_done && (r_idx == 2'd2)) w_state_next = c_DATA;
      c_DATA:       if (w_byte_done && (r_idx == r_last)) w_state_next = c_FINISH;
      c_FINISH:     w_state_next = c_GAP;
      default:      w_state_next = c_INIT_WAIT;
    endcase
  end

  // Output logic: strobe in the first cycle of each byte, bus handshake
  always_comb begin
    w_byte_state = (r_state == c_INIT_RSTEN) || (r_state == c_INIT_RST) ||
                   (r_state == c_CMD) || (r_state == c_ADDR) || (r_state == c_DATA);
    w_framed_next = (w_state_next == c_INIT_RSTEN) || (w_state_next == c_INIT_RST) ||
                    (w_state_next == c_CMD) || (w_state_next == c_ADDR) ||
                    (w_state_next == c_DATA);
    w_tx = 8'h00;
    case (r_state)
      c_INIT_RSTEN: w_tx = 8'h66;
      c_INIT_RST:   w_tx = 8'h99;
      c_CMD:        w_tx = r_is_wr ? CMD_WRITE : CMD_READ;
      c_ADDR: begin
        case (r_idx)
          2'd0:    w_tx = r_addr[23:16];
          2'd1:    w_tx = r_addr[15:8];
          default: w_tx = r_addr[7:0];
        endcase
      end
      c_DATA:       w_tx = r_is_wr ? r_wdata[{r_idx, 3'b000} +: 8] : 8'h00;
      default:      w_tx = 8'h00;
    endcase
    spi_strb     = w_byte_state && !r_issued;
    spi_tx       = spi_strb ? w_tx : 8'h00;
    bus.mem_busy = (r_state != c_IDLE);
    bus.mem_done = (r_state == c_FINISH);
  end

  // Chip enable follows the next state so it is low before the first strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ce_b <= 1'b1;
    else       r_ce_b <= !w_framed_next;
  end

  // Datapath: counters, request latch, byte sequencing and read capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_issued <= 1'b0;
      r_idx    <= 2'd0;
      r_addr   <= 24'd0;
      r_wdata  <= 32'd0;
      r_is_wr  <= 1'b0;
      r_first  <= 2'd0;
      r_last   <= 2'd0;
      r_rx     <= 24'd0;
      r_rdata  <= 32'd0;
    end else begin
      r_cnt <= (w_state_next != r_state) ? '0 : r_cnt + 1'b1;

      if (w_byte_done)   r_issued <= 1'b0;
      else if (spi_strb) r_issued <= 1'b1;

      if (w_accept) begin
        r_is_wr <= w_req_wr;
        r_wdata <= bus.mem_wdata;
        r_first <= w_req_wr ? w_first : 2'd0;
        r_last  <= w_req_wr ? w_last  : 2'd3;
        r_addr  <= {bus.mem_addr[23:2], (w_req_wr ? w_first : 2'd0)};
        r_idx   <= 2'd0;
      end else if (w_byte_done) begin
        case (r_state)
          c_CMD:   r_idx <= 2'd0;
          c_ADDR:  r_idx <= (r_idx == 2'd2) ? r_first : r_idx + 2'd1;
          c_DATA:  r_idx <= r_idx + 2'd1;
          default: r_idx <= r_idx;
        endcase
      end

      if (w_byte_done && (r_state == c_DATA) && !r_is_wr) begin
        if (r_idx == 2'd3) r_rdata <= {spi_rx, r_rx};
        else               r_rx[{r_idx, 3'b000} +: 8] <= spi_rx;
      end
    end
  end

endmodule

`default_nettype wire
